// File: rtl/program_sequencer.sv
// Purpose     : fetch/decode/execute controller for the accumulator datapath; owns PC and IR and adds JMP/HALT.
// Latency     : zero-wait memories give 2 cycles per single-cycle op, 3 per memory op and 2 per JMP to the next fetch.
// Backpressure: each request is held until its ack; with TIMEOUT>0 an ack that never comes halts the core and sets a sticky error.
//
// Ports
//   i_clk, i_rst_n            rising-edge clock, synchronous active-low reset
//   i_start                   launch from IDLE / resume from HALTED (ignored while busy)
//   o_pmem_addr, o_pmem_req   program fetch address (= PC) and request
//   i_pmem_ack, i_pmem_data   fetch data valid and the fetched instruction
//   o_instruction             instruction register, feeds the decoder
//   o_exec_stb                one-cycle commit strobe qualifying decoder CEs and memory writes
//   o_dmem_req, i_dmem_ack    data-memory handshake for LDM/STM
//   o_pc                      current program counter
//   o_busy, o_halted          activity status
//   o_timeout_err             sticky ack-timeout flag
module program_sequencer #(
    parameter int unsigned         PC_WIDTH   = 10,
    parameter logic [PC_WIDTH-1:0] RST_VECTOR = '0,
    parameter int unsigned         TIMEOUT    = 0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    output logic [PC_WIDTH-1:0] o_pmem_addr,
    output logic                o_pmem_req,
    input  logic                i_pmem_ack,
    input  logic [15:0]         i_pmem_data,
    output logic [15:0]         o_instruction,
    output logic                o_exec_stb,
    output logic                o_dmem_req,
    input  logic                i_dmem_ack,
    output logic [PC_WIDTH-1:0] o_pc,
    output logic                o_busy,
    output logic                o_halted,
    output logic                o_timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    // The timeout counter only ever has to hold 0..TIMEOUT-1: the cycle that
    // would take it to TIMEOUT is the cycle the sequencer gives up.
    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam int          CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TO_LASTV = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LASTV);

    state_t                state_q;
    state_t                state_d;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [PC_WIDTH-1:0]   pc_d;
    logic [PC_WIDTH-1:0]   pc_inc;
    logic [PC_WIDTH-1:0]   jmp_target;
    logic [15:0]           ir_q;
    logic                  ir_load;
    logic [CNT_W-1:0]      to_cnt_q;
    logic                  to_err_q;
    logic                  to_hit;
    logic                  to_fire;
    logic                  waiting;
    logic                  exec_stb;
    logic                  pmem_req;
    logic                  dmem_req;

    // Instruction classification straight off the IR.
    logic [3:0]            opcode;
    logic                  is_mem;
    logic                  is_jmp;
    logic                  is_halt;

    assign opcode  = ir_q[5:2];
    assign is_mem  = (ir_q[5:3] == 3'b100) || (ir_q[5:3] == 3'b110);
    assign is_jmp  = (opcode == 4'b0110);
    assign is_halt = (opcode == 4'b0111);

    // PC arithmetic wraps modulo 2^PC_WIDTH with no flag.
    assign pc_inc = pc_q + PC_WIDTH'(1);

    // Jump target is IR[15:6]: truncated for narrow PCs, zero-extended for wide ones.
    generate
        if (PC_WIDTH <= 10) begin : g_tgt_narrow
            assign jmp_target = ir_q[6 +: PC_WIDTH];
        end else begin : g_tgt_wide
            assign jmp_target = {{(PC_WIDTH - 10){1'b0}}, ir_q[15:6]};
        end
    endgenerate

    // A handshake is outstanding in FETCH and MEM; only then can a timeout occur.
    assign waiting = (state_q == S_FETCH) || (state_q == S_MEM);
    assign to_hit  = TO_EN && (to_cnt_q == TO_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RST_VECTOR;
            ir_q     <= 16'h0000;
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (ir_load) begin
                ir_q <= i_pmem_data;
            end
            if (to_fire) begin
                to_err_q <= 1'b1;
            end
            // Any state change restarts the count, which covers every entry
            // into FETCH or MEM; it only advances while a request is unanswered.
            if (state_d != state_q) begin
                to_cnt_q <= '0;
            end else if (waiting && TO_EN) begin
                to_cnt_q <= to_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_load  = 1'b0;
        exec_stb = 1'b0;
        pmem_req = 1'b0;
        dmem_req = 1'b0;
        to_fire  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                pmem_req = 1'b1;
                // An ack in the cycle the counter expires still wins.
                if (i_pmem_ack) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else if (to_hit) begin
                    to_fire = 1'b1;
                    state_d = S_HALTED;
                end
            end

            S_DECODE: begin
                if (is_mem) begin
                    // Commit is deferred to the data-memory ack.
                    state_d = S_MEM;
                end else if (is_jmp) begin
                    pc_d    = jmp_target;
                    state_d = S_FETCH;
                end else if (is_halt) begin
                    // PC stays on the HALT; resume steps past it.
                    state_d = S_HALTED;
                end else begin
                    exec_stb = 1'b1;
                    pc_d     = pc_inc;
                    state_d  = S_FETCH;
                end
            end

            S_MEM: begin
                dmem_req = 1'b1;
                if (i_dmem_ack) begin
                    // LDM data capture and STM write both commit on this strobe.
                    exec_stb = 1'b1;
                    pc_d     = pc_inc;
                    state_d  = S_FETCH;
                end else if (to_hit) begin
                    to_fire = 1'b1;
                    state_d = S_HALTED;
                end
            end

            S_HALTED: begin
                if (i_start) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Requests and status decode from the registered state, so a reset or a
    // timeout drops the request at the very edge that changes state.
    assign o_pmem_addr   = pc_q;
    assign o_pmem_req    = pmem_req;
    assign o_dmem_req    = dmem_req;
    assign o_exec_stb    = exec_stb;
    assign o_instruction = ir_q;
    assign o_pc          = pc_q;
    assign o_busy        = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_MEM);
    assign o_halted      = (state_q == S_HALTED);
    assign o_timeout_err = to_err_q;

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
Multi-cycle fetch/decode/execute controller for the accumulator datapath.
- Fetches 16-bit instructions from program memory into an instruction register, which drives the instruction decoder.
- Issues a one-cycle commit strobe that qualifies the decoder's clock-enables and memory write.
- Stalls on data-memory handshakes.
- Owns the program counter, and implements JMP and HALT on the two unused opcodes 0110 and 0111.

Parameters:
PC_WIDTH, 10, program counter and program-memory address width.
RST_VECTOR, 0, PC value loaded at reset.
TIMEOUT, 0, max cycles waiting for any ack before error; 0 = wait forever.

Ports:
i_clk  input  1  clock, rising edge.
i_rst_n  input  1  synchronous active-low reset.
i_start  input  1  launch from IDLE / resume from HALTED.
o_pmem_addr  output  PC_WIDTH  program-memory address (= PC).
o_pmem_req  output  1  program fetch request.
i_pmem_ack  input  1  fetch data valid.
i_pmem_data  input  16  fetched instruction.
o_instruction  output  16  instruction register, feeds the decoder.
o_exec_stb  output  1  one-cycle commit strobe for decoder-driven CEs/writes.
o_dmem_req  output  1  data-memory access request (LDM/STM).
i_dmem_ack  input  1  data-memory access complete.
o_pc  output  PC_WIDTH  current PC.
o_busy  output  1  state not IDLE/HALTED.
o_halted  output  1  state is HALTED.
o_timeout_err  output  1  sticky ack-timeout flag.

Behaviour:
- Reset (i_rst_n=0 at edge, dominates everything): state=IDLE, PC=RST_VECTOR, IR=16'h0000, timeout counter=0, o_timeout_err=0. o_pmem_req, o_dmem_req, o_exec_stb, o_busy and o_halted are all 0. Reset mid-handshake drops requests at that edge; no ack is honoured afterwards.
- Opcode field is IR[5:2]:
  - memory op: IR[5:3]=100 (STM) or 110 (LDM).
  - JMP: 0110; target = IR[15:6], low PC_WIDTH bits, zero-extended if PC_WIDTH>10.
  - HALT: 0111.
  - all others: single-cycle op (ALU, ST, LD, direct LD).
- States: IDLE, FETCH, DECODE, MEM, HALTED.
- IDLE: all requests 0; i_start=1 -> FETCH.
- FETCH: o_pmem_req=1, o_pmem_addr=PC; request held until i_pmem_ack. On ack: IR<=i_pmem_data, -> DECODE. Ack in the same cycle the request rises is legal (zero-wait).
- DECODE: IR stable, exactly one cycle.
  - single-cycle op: o_exec_stb=1, PC<=PC+1, -> FETCH.
  - memory op: -> MEM; no strobe yet.
  - JMP: PC<=target, -> FETCH; no strobe.
  - HALT: -> HALTED; PC unchanged (points at the HALT); no strobe.
- MEM: o_dmem_req=1 until i_dmem_ack. In the ack cycle: o_exec_stb=1, o_dmem_req=1, PC<=PC+1, -> FETCH. LDM data and STM write commit on that strobe.
- HALTED: o_halted=1; i_start=1 -> PC<=PC+1, -> FETCH.
- i_start is ignored in FETCH/DECODE/MEM.
- Acks arriving while the matching request is low are ignored.
- Latency (zero-wait memories): single-cycle op = 2 cycles/instr, memory op = 3, JMP = 2 to the next fetch.
- PC arithmetic is modulo 2^PC_WIDTH: all-ones +1 wraps to 0 with no flag.
- o_exec_stb is never high in two consecutive cycles and never outside DECODE/MEM.
- Timeout (TIMEOUT>0):
  - Counter clears on entry to FETCH or MEM and increments each cycle the ack is absent.
  - When the counter reaches TIMEOUT without ack: o_timeout_err<=1 (sticky until reset), request drops, -> HALTED, no strobe, PC unchanged.
  - An ack arriving in the same cycle the counter reaches TIMEOUT wins; no error.

Test Plan:
- Reset then i_start with zero-wait pmem holding ALU op 16'h0004 at 0..3 -> o_exec_stb pulses every 2nd cycle, o_pc 0->1->2->3, o_busy=1.
- LDM (IR[5:2]=1100) at PC 5, i_dmem_ack delayed 3 cycles -> o_dmem_req high 4 cycles, single o_exec_stb in the ack cycle, o_pc=6 afterwards.
- JMP 16'h0C98 (target 0x032) at PC 7 -> no strobe, next o_pmem_addr=0x032. PC_WIDTH=10 at PC=0x3FF with ALU op -> next fetch address 0x000.
- HALT 16'h001C at PC 9 -> o_halted=1, o_pc=9, requests 0. i_start pulse -> fetch at 10. i_start during FETCH -> no effect.
- TIMEOUT=4, pmem never acks -> o_pmem_req high 4 cycles then 0, o_timeout_err=1, o_halted=1. With ack on the 4th cycle -> no error.
- Assert i_rst_n=0 while in MEM with o_dmem_req=1 -> next cycle IDLE, PC=RST_VECTOR, all outputs 0, and a late i_dmem_ack causes no strobe.
